// File: rtl/serial_link_pkg.sv
// Shared definitions for the LSB-first 8-bit serial link.
// Contents:
//   BYTE_W       - width of one link byte
//   DEFAULT_SYNC - alignment byte; the serializer also idles on this pattern
//   rx_state_t   - receiver alignment state
package serial_link_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] DEFAULT_SYNC = 8'hAA;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/serial_byte_rx_fifo.sv
// byte_fifo: synchronous byte FIFO with drop-on-full reporting.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   push        - write push_data unless full (a same-edge pop frees the slot)
//   push_data   - byte to write
//   pop         - remove head entry; ignored when empty
//   head        - registered head entry
//   empty       - FIFO holds no entries
//   level       - occupancy, 0..DEPTH
//   dropped     - single-cycle: a push was refused because the FIFO was full
module byte_fifo
    import serial_link_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [BYTE_W-1:0]       push_data,
    input  logic                    pop,
    output logic [BYTE_W-1:0]       head,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    dropped
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    // Extra MSB on each pointer is the wrap bit separating full from empty.
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the head slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && !do_push;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: receive end of the LSB-first serial byte link.
// Hunts for SYNC_WORD, requires SYNC_COUNT further aligned sync bytes to lock,
// then deserializes every byte into a small FIFO with a valid/ready output.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   enable      - bit strobe; in is sampled only when high
//   in          - serial data, LSB first
//   resync      - synchronous pulse back to HUNT (FIFO contents kept)
//   data_out    - FIFO head byte
//   data_valid  - FIFO non-empty
//   data_ready  - consumer accepts head when data_valid && data_ready
//   locked      - receiver is in LOCKED
//   overflow    - sticky: a byte was dropped on a full FIFO
//   fifo_level  - FIFO occupancy
module serial_byte_rx
    import serial_link_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD  = DEFAULT_SYNC,
    parameter int unsigned       SYNC_COUNT = 2,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in,
    input  logic                         resync,
    output logic [BYTE_W-1:0]            data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic                         locked,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    // Value of sync_cnt on the aligned sync byte that completes lock.
    localparam logic [2:0] SYNC_LAST = 3'(SYNC_COUNT - 1);

    rx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]        sync_cnt_q, sync_cnt_d;
    logic              overflow_q, overflow_d;
    logic [BYTE_W-1:0] next_byte;
    logic              push;
    logic              fifo_empty;
    logic              dropped;

    assign next_byte = {in, sr_q[BYTE_W-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        overflow_d = overflow_q | dropped;
        push       = 1'b0;

        if (resync) begin
            // Takes priority over a coincident bit, which is discarded.
            state_d    = HUNT;
            sr_d       = '0;
            bit_cnt_d  = '0;
            sync_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (enable) begin
            sr_d      = next_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            unique case (state_q)
                HUNT: begin
                    bit_cnt_d = '0;
                    if (next_byte == SYNC_WORD) begin
                        state_d    = VERIFY;
                        sync_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    if (bit_cnt_q == 3'd7) begin
                        if (next_byte != SYNC_WORD) begin
                            state_d    = HUNT;
                            bit_cnt_d  = '0;
                            sync_cnt_d = '0;
                        end else if (sync_cnt_q == SYNC_LAST) begin
                            state_d = LOCKED;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 3'd1;
                        end
                    end
                end
                LOCKED: begin
                    push = (bit_cnt_q == 3'd7);
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (next_byte),
        .pop       (data_ready),
        .head      (data_out),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .dropped   (dropped)
    );

    assign data_valid = !fifo_empty;
    assign locked     = (state_q == LOCKED);
    assign overflow   = overflow_q;

endmodule
